i2c_cfg_sequencer: RTL
======================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Table-driven I2C register-configuration sequencer that drives the existing byte-level I2C master
//  (cmd/addr_dev/addr_reg/data_wr/i2c_rqt/i2c_done handshake). Steps through an external command table
//  after reset or on a start pulse, and supports 8/16-bit register addresses, 8/16-bit data, timed delays,
//  a retry policy and optional read-back verify. Configures the HDMI TX and the CSI-2 sensors.
// PARAMETERS
//  NUM_ENTRIES   32      table depth; IW = $clog2(NUM_ENTRIES)
//  DEV_ADDR      7'h3B   7-bit I2C device address driven on addr_dev
//  DELAY_UNIT    27000   clk cycles per DELAY-op tick
//  GAP_CYCLES    16      idle clk cycles between consecutive transactions (0 = none)
//  TIMEOUT_CYC   2**20   max cycles waiting for i2c_done falling edge before the attempt counts as failed
//  MAX_RETRY     3       retries per entry after the first attempt
//  AUTO_START    1       1 = start sequence on reset release
// PORTS
//  clk          in   1    system clock
//  rst_n        in   1    asynchronous active-low reset
//  start        in   1    1-cycle pulse; (re)starts sequence from entry 0 when not busy
//  tbl_idx      out  IW   table read index
//  tbl_entry    in   34   {op[1:0],reg_H[7:0],reg_L[7:0],dat_H[7:0],dat_L[7:0]}; valid 1 cycle after tbl_idx
//  cmd          out  1    1 = WRITE, 0 = READ
//  addr_dev     out  7    device address (DEV_ADDR)
//  addr_reg_H   out  8    register address high byte
//  addr_reg_L   out  8    register address low byte
//  data_wr_H    out  8    write data high byte
//  data_wr_L    out  8    write data low byte
//  i2c_rqt      out  1    transaction request to the I2C master
//  i2c_done     in   1    master busy/done; falling edge = transaction complete
//  data_rdy     in   1    read byte valid strobe
//  data_rd      in   8    read byte
//  busy         out  1    sequence in progress
//  config_done  out  1    sticky; table completed without error
//  config_err   out  1    sticky; entry failed after MAX_RETRY retries
//  err_idx      out  IW   index of failing entry (valid when config_err=1)
// BEHAVIOUR
//  Reset: i2c_rqt=0, cmd=1, addr_dev=DEV_ADDR, addr/data regs=0, tbl_idx=0, busy=0, config_done=0,
//   config_err=0, err_idx=0, state=IDLE. Assertion mid-transaction drops i2c_rqt immediately; the master
//   must abort.
//  Ops: 00 WRITE; 01 WRITE+VERIFY; 10 DELAY {dat_H,dat_L}*DELAY_UNIT cycles (0 = no wait); 11 END.
//  i2c_done is registered once; done_neg = ~i2c_done & i2c_done_q.
//  States: IDLE->FETCH (AUTO_START after reset, or start) -> DECODE (entry registered) -> ISSUE|DELAY|DONE.
//   ISSUE: load cmd/addr/data and set i2c_rqt=1; fields stay stable while i2c_rqt=1.
//   WAIT: i2c_rqt held until done_neg, then cleared in the same edge -> GAP, or RD_ISSUE for op 01.
//   RD_ISSUE/RD_WAIT: cmd=0, same regs; data_rd captured on each data_rdy; done_neg -> CHECK.
//   CHECK: captured byte == dat_L -> GAP; else retry. (16-bit regs: last byte read compares with dat_L.)
//   GAP: GAP_CYCLES idle, then tbl_idx++ -> FETCH. tbl_idx==NUM_ENTRIES-1 completes -> DONE.
//   DONE: config_done=1, busy=0. ERR: config_err=1, err_idx=failing tbl_idx, busy=0.
//  Retry: timeout (TIMEOUT_CYC cycles without done_neg) or verify mismatch -> i2c_rqt=0, GAP, reissue same
//   entry; retry count resets per entry; fail when count > MAX_RETRY -> ERR.
//  busy=1 in all states except IDLE/DONE/ERR. start while busy is ignored. start in DONE/ERR clears
//   config_done/config_err and restarts at entry 0. A start coincident with reset release is ignored.
//  done_neg seen outside WAIT/RD_WAIT is ignored. Latency from start to first i2c_rqt: 3 cycles.
// CONFIGURATION
//  I2C_CFG_VERIFY_EN defined: op 01 performs read-back verify as above.
//  Not defined: op 01 behaves exactly as op 00; RD_* and CHECK states and the data_rd capture register
//   are removed; data_rdy and data_rd are unused; mismatch retries cannot occur.
// TESTING
//  T1 reset release, AUTO_START=1, table {WR 0x1E=0x00, WR 0x08=0x60, END}, model acks in 100 clk -> exactly 2
//   rqt pulses with matching fields; config_done=1, busy=0.
//  T2 DELAY op dat=0x0003, DELAY_UNIT=10 -> gap between surrounding i2c_rqt rises = 30 + GAP + fetch cycles (±1).
//  T3 VERIFY_EN, WR+VERIFY 0xC7=0x00, model returns 0x5A twice then 0x00 -> 3 write/read pairs; config_done=1.
//  T4 model never drops i2c_done, MAX_RETRY=3 -> 4 attempts, each TIMEOUT_CYC long; config_err=1,
//   err_idx=failing entry.
//  T5 start pulsed while busy -> ignored; start after DONE -> flags clear, replay from entry 0.
//  T6 rst_n low while i2c_rqt=1 -> i2c_rqt=0 asynchronously; after release, sequence restarts at entry 0.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks an external register-configuration table and drives a
// byte-level I2C master through its rqt/done handshake. Supports plain writes,
// timed delays, per-entry retries on timeout, and (optionally) write+read-back verify.
// Optional feature macro: I2C_CFG_VERIFY_EN enables read-back verify for op 01;
// without it op 01 is a plain write and the read path is not built.
module i2c_cfg_sequencer #(
  parameter int         NUM_ENTRIES = 32,
  parameter logic [6:0] DEV_ADDR    = 7'h3B,
  parameter int         DELAY_UNIT  = 27000,
  parameter int         GAP_CYCLES  = 16,
  parameter int         TIMEOUT_CYC = 2**20,
  parameter int         MAX_RETRY   = 3,
  parameter bit         AUTO_START  = 1'b1,
  localparam int        IW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [IW-1:0] tbl_idx,
  input  logic [33:0]   tbl_entry,
  output logic          cmd,
  output logic [6:0]    addr_dev,
  output logic [7:0]    addr_reg_H,
  output logic [7:0]    addr_reg_L,
  output logic [7:0]    data_wr_H,
  output logic [7:0]    data_wr_L,
  output logic          i2c_rqt,
  input  logic          i2c_done,
  input  logic          data_rdy,
  input  logic [7:0]    data_rd,
  output logic          busy,
  output logic          config_done,
  output logic          config_err,
  output logic [IW-1:0] err_idx
);

  // One shared cycle counter serves gap, timeout and delay-unit timing.
  localparam int CMAX0 = (TIMEOUT_CYC > DELAY_UNIT) ? TIMEOUT_CYC : DELAY_UNIT;
  localparam int CMAX  = (CMAX0 > GAP_CYCLES) ? CMAX0 : GAP_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] DU_LAST   = CW'(DELAY_UNIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_ENTRIES - 1);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_WRV = 2'b01;
  localparam logic [1:0] OP_DLY = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_GAP, S_DELAY, S_DONE, S_ERR
`ifdef I2C_CFG_VERIFY_EN
    , S_RD_ISSUE, S_RD_WAIT, S_CHECK
`endif
  } state_t;

  state_t        r_state;
  logic          r_live;      // low only on the first edge after reset release
  logic          r_done_q;
  logic [33:0]   r_entry;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_ticks;
  logic [RW-1:0] r_retry;
  logic          r_again;     // GAP exit reissues the current entry
  logic [IW-1:0] r_tbl_idx;
  logic          r_cmd;
  logic [7:0]    r_addr_H, r_addr_L, r_data_H, r_data_L;
  logic          r_rqt;
  logic          r_busy;
  logic          r_cfg_done;
  logic          r_cfg_err;
  logic [IW-1:0] r_err_idx;
`ifdef I2C_CFG_VERIFY_EN
  logic [7:0]    r_rd;
`else
  logic          w_unused_rd;
  assign w_unused_rd = ^{data_rdy, data_rd};
`endif

  logic w_done_neg;
  logic w_fail;

  assign w_done_neg = ~i2c_done & r_done_q;

  // Attempt failure: no completion within the timeout, or a read-back mismatch.
  always_comb begin
    w_fail = 1'b0;
    case (r_state)
      S_WAIT:    w_fail = !w_done_neg && (r_cnt == TO_LAST);
`ifdef I2C_CFG_VERIFY_EN
      S_RD_WAIT: w_fail = !w_done_neg && (r_cnt == TO_LAST);
      S_CHECK:   w_fail = (r_rd != r_entry[7:0]);
`endif
      default:   w_fail = 1'b0;
    endcase
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_live     <= 1'b0;
      r_done_q   <= 1'b0;
      r_entry    <= '0;
      r_cnt      <= '0;
      r_ticks    <= '0;
      r_retry    <= '0;
      r_again    <= 1'b0;
      r_tbl_idx  <= '0;
      r_cmd      <= 1'b1;
      r_addr_H   <= '0;
      r_addr_L   <= '0;
      r_data_H   <= '0;
      r_data_L   <= '0;
      r_rqt      <= 1'b0;
      r_busy     <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_err_idx  <= '0;
`ifdef I2C_CFG_VERIFY_EN
      r_rd       <= '0;
`endif
    end else begin
      r_live   <= 1'b1;
      r_done_q <= i2c_done;
      if (w_fail) begin
        // Abandon this attempt; either give up on the entry or back off and retry.
        r_rqt <= 1'b0;
        r_cnt <= '0;
        if (r_retry == RETRY_MAX) begin
          r_state   <= S_ERR;
          r_busy    <= 1'b0;
          r_cfg_err <= 1'b1;
          r_err_idx <= r_tbl_idx;
        end else begin
          r_retry <= r_retry + 1'b1;
          r_again <= 1'b1;
          r_state <= S_GAP;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            // Auto-start fires on the first edge; an external start that early is ignored.
            if ((AUTO_START && !r_live) || (start && r_live)) begin
              r_tbl_idx <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
          S_DONE, S_ERR: begin
            if (start) begin
              r_cfg_done <= 1'b0;
              r_cfg_err  <= 1'b0;
              r_tbl_idx  <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
          // Table read is registered externally; entry is valid in DECODE.
          S_FETCH: r_state <= S_DECODE;
          S_DECODE: begin
            r_entry <= tbl_entry;
            r_retry <= '0;
            r_again <= 1'b0;
            r_cnt   <= '0;
            case (tbl_entry[33:32])
              OP_DLY: begin
                r_ticks <= tbl_entry[15:0];
                r_state <= S_DELAY;
              end
              OP_END: begin
                r_busy     <= 1'b0;
                r_cfg_done <= 1'b1;
                r_state    <= S_DONE;
              end
              default: r_state <= S_ISSUE;
            endcase
          end
          S_ISSUE: begin
            r_cmd    <= 1'b1;
            r_addr_H <= r_entry[31:24];
            r_addr_L <= r_entry[23:16];
            r_data_H <= r_entry[15:8];
            r_data_L <= r_entry[7:0];
            r_rqt    <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            if (w_done_neg) begin
              r_rqt <= 1'b0;
              r_cnt <= '0;
`ifdef I2C_CFG_VERIFY_EN
              if (r_entry[33:32] == OP_WRV) r_state <= S_RD_ISSUE;
              else                          r_state <= S_GAP;
`else
              r_state <= S_GAP;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`ifdef I2C_CFG_VERIFY_EN
          S_RD_ISSUE: begin
            r_cmd   <= 1'b0;
            r_rqt   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (data_rdy) r_rd <= data_rd;
            if (w_done_neg) begin
              r_rqt   <= 1'b0;
              r_state <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            r_cnt   <= '0;
            r_again <= 1'b0;
            r_state <= S_GAP;
          end
`endif
          S_DELAY: begin
            if (r_ticks == '0) begin
              r_cnt   <= '0;
              r_again <= 1'b0;
              r_state <= S_GAP;
            end else if (r_cnt == DU_LAST) begin
              r_cnt   <= '0;
              r_ticks <= r_ticks - 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_cnt <= '0;
              if (r_again) begin
                r_state <= S_ISSUE;
              end else if (r_tbl_idx == IDX_LAST) begin
                r_busy     <= 1'b0;
                r_cfg_done <= 1'b1;
                r_state    <= S_DONE;
              end else begin
                r_tbl_idx <= r_tbl_idx + 1'b1;
                r_state   <= S_FETCH;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tbl_idx     = r_tbl_idx;
  assign cmd         = r_cmd;
  assign addr_dev    = DEV_ADDR;
  assign addr_reg_H  = r_addr_H;
  assign addr_reg_L  = r_addr_L;
  assign data_wr_H   = r_data_H;
  assign data_wr_L   = r_data_L;
  assign i2c_rqt     = r_rqt;
  assign busy        = r_busy;
  assign config_done = r_cfg_done;
  assign config_err  = r_cfg_err;
  assign err_idx     = r_err_idx;

endmodule
